// File: rtl/instb_pkg.sv
// Shared definitions for the interleaved instruction buffer: lane/bank width
// derivation, response FIFO depth and bank/row address split helpers.
package instb_pkg;

    localparam int unsigned FIFO_DEPTH = 32'd2;

    function automatic int unsigned calc_bw(input int unsigned dw);
        return dw / 32'd8;
    endfunction

    function automatic int unsigned calc_bs(input int unsigned nbank);
        return $clog2(nbank);
    endfunction

    function automatic int unsigned addr_bank(input int unsigned addr, input int unsigned bs);
        return addr & ((32'd1 << bs) - 32'd1);
    endfunction

    function automatic int unsigned addr_row(input int unsigned addr, input int unsigned bs);
        return addr >> bs;
    endfunction

endpackage

// File: rtl/instb_bank_ram.sv
// One bank of the instruction buffer: simple dual-port RAM with byte-enabled
// write and a registered, read-first read port.
module instb_bank_ram #(
    parameter int unsigned RW = 11,
    parameter int unsigned DW = 128,
    parameter int unsigned BW = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [BW-1:0] be,
    input  logic [RW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [RW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    localparam int unsigned DEPTH = 32'd1 << RW;

`ifdef FPGA
    (* ram_style = "block" *) logic [DW-1:0] mem_q [DEPTH];
`else
    logic [DW-1:0] mem_q [DEPTH];
`endif

    logic [DW-1:0] rdata_q;
    logic [DW-1:0] rdata_d;

    always_comb begin
        if (re) begin
            rdata_d = mem_q[raddr];
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Read samples the array before this cycle's write, so collisions return old data.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < int'(BW); i++) begin
                if (be[i]) begin
                    mem_q[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/instb_buf_ctrl.sv
// Instruction buffer controller: NBANK interleaved banks, valid/ready read path
// with a 2-entry fall-through response FIFO, same-cycle write bypass and flush.
module instb_buf_ctrl
    import instb_pkg::*;
#(
    parameter  int unsigned AW        = 12,
    parameter  int unsigned DW        = 128,
    parameter  int unsigned NBANK     = 2,
    parameter  int unsigned RD_BYPASS = 1,
    localparam int unsigned BW        = calc_bw(DW),
    localparam int unsigned BS        = calc_bs(NBANK)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          wr_en,
    input  logic [BW-1:0] wr_be,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_req_vld,
    output logic          rd_req_rdy,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_rsp_vld,
    input  logic          rd_rsp_rdy,
    output logic [DW-1:0] rd_rsp_data
);

    localparam int unsigned RW     = AW - BS;
    localparam logic [1:0]  FULL_C = 2'(FIFO_DEPTH);

    logic [BS-1:0] wr_bank_s, rd_bank_s;
    logic [RW-1:0] wr_row_s, rd_row_s;
    logic [DW-1:0] bank_rdata_s [NBANK];
    logic          rd_acc_s;
    logic [1:0]    cnt_s;
    logic          fifo_empty_s, push_s, pop_s, pop_fifo_s;
    logic [DW-1:0] infl_word_s;
    logic          rsp_vld_s;
    logic [DW-1:0] rsp_data_s;
    logic          req_rdy_s;

    logic          infl_vld_q, infl_vld_d;
    logic [BS-1:0] infl_bank_q, infl_bank_d;
    logic [BW-1:0] byp_be_q, byp_be_d;
    logic [DW-1:0] byp_data_q, byp_data_d;
    logic [DW-1:0] fifo_data_q [FIFO_DEPTH];
    logic [DW-1:0] fifo_data_d [FIFO_DEPTH];
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [1:0]    fifo_cnt_q, fifo_cnt_d;

    assign wr_bank_s = BS'(addr_bank(32'(wr_addr), BS));
    assign rd_bank_s = BS'(addr_bank(32'(rd_addr), BS));
    assign wr_row_s  = RW'(addr_row(32'(wr_addr), BS));
    assign rd_row_s  = RW'(addr_row(32'(rd_addr), BS));

    assign cnt_s     = fifo_cnt_q + {1'b0, infl_vld_q};
    assign req_rdy_s = !flush & ((cnt_s < FULL_C) | ((cnt_s == FULL_C) & rsp_vld_s & rd_rsp_rdy));
    assign rd_acc_s  = rd_req_vld & req_rdy_s;

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        logic we_s, re_s;
        assign we_s = wr_en & (wr_bank_s == BS'(b));
        assign re_s = rd_acc_s & (rd_bank_s == BS'(b));
        instb_bank_ram #(.RW(RW), .DW(DW), .BW(BW)) u_ram (
            .clk   (clk),
            .we    (we_s),
            .be    (wr_be),
            .waddr (wr_row_s),
            .wdata (wr_data),
            .re    (re_s),
            .raddr (rd_row_s),
            .rdata (bank_rdata_s[b])
        );
    end

    // Capture the bank and any colliding write bytes alongside the accepted read.
    always_comb begin
        infl_vld_d  = rd_acc_s;
        infl_bank_d = infl_bank_q;
        byp_be_d    = byp_be_q;
        byp_data_d  = byp_data_q;
        if (rd_acc_s) begin
            infl_bank_d = rd_bank_s;
            if ((RD_BYPASS != 32'd0) && wr_en && (wr_addr == rd_addr)) begin
                byp_be_d   = wr_be;
                byp_data_d = wr_data;
            end else begin
                byp_be_d   = '0;
                byp_data_d = byp_data_q;
            end
        end else begin
            infl_bank_d = infl_bank_q;
        end
    end

    always_comb begin
        infl_word_s = bank_rdata_s[infl_bank_q];
        for (int i = 0; i < int'(BW); i++) begin
            if (byp_be_q[i]) begin
                infl_word_s[8*i +: 8] = byp_data_q[8*i +: 8];
            end else begin
                infl_word_s[8*i +: 8] = bank_rdata_s[infl_bank_q][8*i +: 8];
            end
        end
    end

    // An empty FIFO lets the in-flight word fall straight through to the output.
    assign fifo_empty_s = (fifo_cnt_q == 2'd0);
    assign rsp_vld_s    = !fifo_empty_s | infl_vld_q;
    assign pop_s        = rsp_vld_s & rd_rsp_rdy;
    assign pop_fifo_s   = pop_s & !fifo_empty_s;
    assign push_s       = infl_vld_q & !(fifo_empty_s & pop_s);

    always_comb begin
        if (!fifo_empty_s) begin
            rsp_data_s = fifo_data_q[rd_ptr_q];
        end else if (infl_vld_q) begin
            rsp_data_s = infl_word_s;
        end else begin
            rsp_data_s = fifo_data_q[rd_ptr_q];
        end
    end

    always_comb begin
        fifo_data_d = fifo_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fifo_cnt_d  = fifo_cnt_q;
        if (flush) begin
            wr_ptr_d   = 1'b0;
            rd_ptr_d   = 1'b0;
            fifo_cnt_d = 2'd0;
        end else begin
            if (push_s) begin
                fifo_data_d[wr_ptr_q] = infl_word_s;
                wr_ptr_d              = ~wr_ptr_q;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_fifo_s) begin
                rd_ptr_d = ~rd_ptr_q;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            fifo_cnt_d = fifo_cnt_q + {1'b0, push_s} - {1'b0, pop_fifo_s};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            infl_vld_q  <= 1'b0;
            infl_bank_q <= '0;
            byp_be_q    <= '0;
            byp_data_q  <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            fifo_cnt_q  <= 2'd0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_data_q[i] <= '0;
            end
        end else begin
            infl_vld_q  <= infl_vld_d;
            infl_bank_q <= infl_bank_d;
            byp_be_q    <= byp_be_d;
            byp_data_q  <= byp_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_data_q[i] <= fifo_data_d[i];
            end
        end
    end

    assign rd_req_rdy  = req_rdy_s;
    assign rd_rsp_vld  = rsp_vld_s;
    assign rd_rsp_data = rsp_data_s;

endmodule

// File: tb/tb_instb_buf_ctrl.sv
// Scoreboard bench for instb_buf_ctrl: bypass and non-bypass instances share
// stimulus; a reference memory model predicts every read response.
module tb_instb_buf_ctrl;

    localparam int AW = 12;
    localparam int DW = 128;
    localparam int BW = 16;

    logic          clk = 1'b0;
    logic          rst_n, flush, wr_en, rd_req_vld, rd_rsp_rdy;
    logic [BW-1:0] wr_be;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [DW-1:0] wr_data;
    logic          rd_req_rdy, rd_rsp_vld, rd_req_rdy_nb, rd_rsp_vld_nb;
    logic [DW-1:0] rd_rsp_data, rd_rsp_data_nb;

    int            checks = 0;
    int            errors = 0;
    int            pops   = 0;
    logic [DW-1:0] mem_m [1 << AW];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] mon_e;

    always #5 clk = ~clk;

    instb_buf_ctrl #(.AW(AW), .DW(DW), .NBANK(2), .RD_BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_req_vld(rd_req_vld), .rd_req_rdy(rd_req_rdy), .rd_addr(rd_addr),
        .rd_rsp_vld(rd_rsp_vld), .rd_rsp_rdy(rd_rsp_rdy), .rd_rsp_data(rd_rsp_data)
    );

    instb_buf_ctrl #(.AW(AW), .DW(DW), .NBANK(2), .RD_BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_req_vld(rd_req_vld), .rd_req_rdy(rd_req_rdy_nb), .rd_addr(rd_addr),
        .rd_rsp_vld(rd_rsp_vld_nb), .rd_rsp_rdy(rd_rsp_rdy), .rd_rsp_data(rd_rsp_data_nb)
    );

    function automatic logic [DW-1:0] pat(input int a);
        logic [7:0] b;
        b = 8'(a);
        return {4{8'h5A, b, 8'hC3, ~b}};
    endfunction

    // Scoreboard: pop on handshake, push the model's answer on accept, then apply the write.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (flush) begin
                exp_q.delete();
            end else begin
                if (rd_rsp_vld && rd_rsp_rdy) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL sb_spurious: got %h with no outstanding request", rd_rsp_data);
                    end else begin
                        mon_e = exp_q.pop_front();
                        pops++;
                        if (rd_rsp_data !== mon_e) begin
                            errors++;
                            $display("FAIL sb_data: got %h expected %h", rd_rsp_data, mon_e);
                        end
                    end
                end
                if (rd_req_vld && rd_req_rdy) begin
                    mon_e = mem_m[rd_addr];
                    if (wr_en && (wr_addr == rd_addr)) begin
                        for (int i = 0; i < BW; i++) begin
                            if (wr_be[i]) mon_e[8*i +: 8] = wr_data[8*i +: 8];
                        end
                    end
                    exp_q.push_back(mon_e);
                end
                checks++;
                if (exp_q.size() > 2) begin
                    errors++;
                    $display("FAIL sb_occupancy: outstanding %0d exceeds 2", exp_q.size());
                end
            end
            if (wr_en) begin
                for (int i = 0; i < BW; i++) begin
                    if (wr_be[i]) mem_m[wr_addr][8*i +: 8] = wr_data[8*i +: 8];
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; wr_en = 1'b0; wr_be = '0; wr_addr = '0; wr_data = '0;
        rd_req_vld = 1'b0; rd_addr = '0; rd_rsp_rdy = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        checks++; if (rd_rsp_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b expected 0", rd_rsp_vld); end
        checks++; if (rd_req_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b expected 1", rd_req_rdy); end
        checks++; if (rd_rsp_data !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", rd_rsp_data); end
        tick();
    endtask

    task automatic init_mem();
        for (int a = 0; a < 16; a++) begin
            wr_en = 1'b1; wr_be = '1; wr_addr = AW'(a); wr_data = pat(a);
            tick();
        end
        wr_en = 1'b0; wr_be = '0;
    endtask

    task automatic test_write_read();
        wr_en = 1'b1; wr_be = '1; wr_addr = 12'd3; wr_data = {16{8'hA5}};
        tick();
        wr_en = 1'b0;
        rd_rsp_rdy = 1'b1; rd_req_vld = 1'b1; rd_addr = 12'd3;
        @(negedge clk);
        checks++; if (rd_req_rdy !== 1'b1) begin errors++; $display("FAIL wr_rd_rdy: got %b expected 1", rd_req_rdy); end
        tick();
        rd_req_vld = 1'b0;
        @(negedge clk);
        checks++; if (rd_rsp_vld !== 1'b1) begin errors++; $display("FAIL wr_rd_latency: vld %b expected 1", rd_rsp_vld); end
        checks++; if (rd_rsp_data !== {16{8'hA5}}) begin errors++; $display("FAIL wr_rd_data: got %h expected a5..", rd_rsp_data); end
        tick();
        rd_req_vld = 1'b1; rd_addr = 12'd2;
        tick();
        rd_req_vld = 1'b0;
        @(negedge clk);
        checks++; if (rd_rsp_data !== pat(2)) begin errors++; $display("FAIL bank0_untouched: got %h expected %h", rd_rsp_data, pat(2)); end
        tick();
    endtask

    task automatic test_back_to_back();
        int start;
        start = pops;
        rd_rsp_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rd_req_vld = 1'b1; rd_addr = AW'(i);
            @(negedge clk);
            checks++; if (rd_req_rdy !== 1'b1) begin errors++; $display("FAIL b2b_rdy: cycle %0d got %b expected 1", i, rd_req_rdy); end
            if (i > 0) begin
                checks++; if (rd_rsp_vld !== 1'b1) begin errors++; $display("FAIL b2b_vld: cycle %0d got %b expected 1", i, rd_rsp_vld); end
            end
            tick();
        end
        rd_req_vld = 1'b0;
        @(negedge clk);
        checks++; if (rd_rsp_vld !== 1'b1) begin errors++; $display("FAIL b2b_last_vld: got %b expected 1", rd_rsp_vld); end
        tick();
        checks++; if (pops - start != 8) begin errors++; $display("FAIL b2b_count: got %0d responses expected 8", pops - start); end
    endtask

    task automatic test_backpressure();
        int acc;
        int start;
        acc = 0; start = pops;
        rd_rsp_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rd_req_vld = 1'b1; rd_addr = AW'(8 + acc);
            @(negedge clk);
            if (rd_req_rdy) acc++;
            tick();
        end
        checks++; if (acc != 2) begin errors++; $display("FAIL bp_accepted: got %0d expected 2", acc); end
        @(negedge clk);
        checks++; if (rd_req_rdy !== 1'b0) begin errors++; $display("FAIL bp_rdy_low: got %b expected 0", rd_req_rdy); end
        checks++; if (rd_rsp_data !== pat(8)) begin errors++; $display("FAIL bp_head_stable: got %h expected %h", rd_rsp_data, pat(8)); end
        tick();
        rd_rsp_rdy = 1'b1; rd_req_vld = 1'b1; rd_addr = 12'd10;
        @(negedge clk);
        checks++; if (rd_req_rdy !== 1'b1) begin errors++; $display("FAIL bp_comb_rdy: got %b expected 1", rd_req_rdy); end
        tick();
        rd_req_vld = 1'b0;
        repeat (4) tick();
        checks++; if (pops - start != 3) begin errors++; $display("FAIL bp_count: got %0d responses expected 3", pops - start); end
    endtask

    task automatic test_collision();
        logic [DW-1:0] merged;
        merged = {{12{8'h22}}, {4{8'h11}}};
        rd_rsp_rdy = 1'b1;
        wr_en = 1'b1; wr_be = '1; wr_addr = 12'd5; wr_data = {16{8'h22}};
        tick();
        wr_be = 16'h000F; wr_data = {16{8'h11}}; rd_req_vld = 1'b1; rd_addr = 12'd5;
        tick();
        wr_en = 1'b0; rd_req_vld = 1'b0;
        @(negedge clk);
        checks++; if (rd_rsp_data !== merged) begin errors++; $display("FAIL col_bypass: got %h expected %h", rd_rsp_data, merged); end
        checks++; if (rd_rsp_data_nb !== {16{8'h22}}) begin errors++; $display("FAIL col_nobypass: got %h expected 22..", rd_rsp_data_nb); end
        checks++; if (rd_rsp_vld_nb !== 1'b1 || rd_req_rdy_nb !== 1'b1) begin errors++; $display("FAIL col_nb_ctrl: vld %b rdy %b expected 1 1", rd_rsp_vld_nb, rd_req_rdy_nb); end
        tick();
        rd_req_vld = 1'b1; rd_addr = 12'd5;
        wr_en = 1'b1; wr_be = '1; wr_addr = 12'd7; wr_data = {16{8'h77}};
        tick();
        wr_en = 1'b0; rd_req_vld = 1'b0;
        @(negedge clk);
        checks++; if (rd_rsp_data_nb !== merged) begin errors++; $display("FAIL col_landed: got %h expected %h", rd_rsp_data_nb, merged); end
        tick();
        rd_req_vld = 1'b1; rd_addr = 12'd7;
        tick();
        rd_req_vld = 1'b0;
        wr_en = 1'b1; wr_be = '1; wr_addr = 12'd7; wr_data = {16{8'h99}};
        @(negedge clk);
        checks++; if (rd_rsp_data !== {16{8'h77}}) begin errors++; $display("FAIL col_inflight: got %h expected 77..", rd_rsp_data); end
        tick();
        wr_en = 1'b0;
    endtask

    task automatic test_flush();
        rd_rsp_rdy = 1'b0;
        rd_req_vld = 1'b1; rd_addr = 12'd0;
        tick();
        rd_addr = 12'd1;
        tick();
        flush = 1'b1; rd_rsp_rdy = 1'b1; rd_addr = 12'd2;
        wr_en = 1'b1; wr_be = '1; wr_addr = 12'd9; wr_data = {16{8'hF1}};
        @(negedge clk);
        checks++; if (rd_req_rdy !== 1'b0) begin errors++; $display("FAIL flush_rdy: got %b expected 0", rd_req_rdy); end
        tick();
        flush = 1'b0; wr_en = 1'b0; rd_req_vld = 1'b0;
        @(negedge clk);
        checks++; if (rd_rsp_vld !== 1'b0) begin errors++; $display("FAIL flush_vld: got %b expected 0", rd_rsp_vld); end
        tick();
        rd_req_vld = 1'b1; rd_addr = 12'd9;
        tick();
        rd_req_vld = 1'b0;
        @(negedge clk);
        checks++; if (rd_rsp_vld !== 1'b1 || rd_rsp_data !== {16{8'hF1}}) begin
            errors++; $display("FAIL flush_newread: vld %b data %h expected 1 f1..", rd_rsp_vld, rd_rsp_data);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        rd_rsp_rdy = 1'b0;
        rd_req_vld = 1'b1; rd_addr = 12'd4;
        tick();
        rd_req_vld = 1'b0;
        @(negedge clk);
        checks++; if (rd_rsp_vld !== 1'b1) begin errors++; $display("FAIL rst_pre_vld: got %b expected 1", rd_rsp_vld); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (rd_rsp_vld !== 1'b0) begin errors++; $display("FAIL rst_async_vld: got %b expected 0", rd_rsp_vld); end
        @(negedge clk);
        #2 rst_n = 1'b1;
        tick();
        @(negedge clk);
        checks++; if (rd_req_rdy !== 1'b1 || rd_rsp_vld !== 1'b0) begin
            errors++; $display("FAIL rst_post: rdy %b vld %b expected 1 0", rd_req_rdy, rd_rsp_vld);
        end
        tick();
        rd_rsp_rdy = 1'b1; rd_req_vld = 1'b1; rd_addr = 12'd3;
        tick();
        rd_req_vld = 1'b0;
        @(negedge clk);
        checks++; if (rd_rsp_data !== {16{8'hA5}}) begin errors++; $display("FAIL rst_mem_kept: got %h expected a5..", rd_rsp_data); end
        tick();
    endtask

    initial begin
        test_reset();
        init_mem();
        test_write_read();
        test_back_to_back();
        test_backpressure();
        test_collision();
        test_flush();
        test_reset_mid();
        rd_rsp_rdy = 1'b1;
        repeat (3) tick();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL drain: %0d responses never returned", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
